// File: rtl/mult32s_booth4_csa_seq_pkg.sv
// Shared constants, state/digit enums and the radix-4 Booth recoding helper
// for the sequential Booth/CSA multiplier front end.
package mult_seq_pkg;

  localparam int W  = 32;
  localparam int PW = 64;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_e;

  // Radix-4 Booth recoding of window {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_e booth_digit(input logic [2:0] win);
    booth_e d;
    case (win)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mult32s_booth4_csa_seq_if.sv
// Operand/result handshake bundle between the multiplier and its neighbours.
// master: operand producer / result consumer. slave: the multiplier.
interface mult32s_booth4_csa_seq_if;

  logic                                in_valid;
  logic                                in_ready;
  logic signed [mult_seq_pkg::W-1:0]   a;
  logic signed [mult_seq_pkg::W-1:0]   b;
  logic                                out_valid;
  logic                                out_ready;
  logic        [mult_seq_pkg::PW-1:0]  row_s;
  logic        [mult_seq_pkg::PW-1:0]  row_c;
  logic        [4:0]                   digits;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, row_s, row_c, digits
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, row_s, row_c, digits
  );

endinterface

// File: rtl/mult32s_booth4_csa_seq_cpa.sv
// MG_CPA: downstream 64-bit carry-propagate adder that resolves the
// carry-save rows into the product (mod 2^64).
module MG_CPA
  import mult_seq_pkg::*;
(
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [PW-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mult32s_booth4_csa_seq_pp_sel.sv
// Booth partial-product selector: picks 0/+A/+2A/-A/-2A from the recoded
// window and aligns it to digit position 2*idx (all mod 2^64).
module booth4_pp_sel
  import mult_seq_pkg::*;
(
  input  logic        [2:0]    win,
  input  logic signed [PW-1:0] a_ext,
  input  logic signed [PW-1:0] na_ext,
  input  logic        [4:0]    idx,
  output logic        [PW-1:0] pp
);

  booth_e            dig;
  logic   [PW-1:0]   base;

  // Digit select then positional shift
  always_comb begin
    dig  = booth_digit(win);
    base = '0;
    case (dig)
      POS1:    base = a_ext;
      POS2:    base = a_ext << 1;
      NEG1:    base = na_ext;
      NEG2:    base = na_ext << 1;
      default: base = '0;
    endcase
    pp = base << {idx, 1'b0};
  end

endmodule

// File: rtl/mult32s_booth4_csa_seq.sv
// Sequential radix-4 Booth partial-product accumulator, 32x32 signed.
// One Booth digit per cycle is compressed into a 64-bit carry-save pair.
// Optional macro MULT_CSA_SEQ_EARLY_TERM_EN: stop RUN as soon as every
// remaining multiplier digit is zero (numeric result unchanged).
module mult32s_booth4_csa_seq
  import mult_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  mult32s_booth4_csa_seq_if.slave bus
);

  state_e                state_q, state_d;
  logic signed [PW-1:0]  a_q, a_d;
  logic signed [PW-1:0]  na_q, na_d;
  logic signed [W-1:0]   b_q, b_d;
  logic        [PW-1:0]  s_q, s_d;
  logic        [PW-1:0]  c_q, c_d;
  logic        [4:0]     i_q, i_d;
  logic        [4:0]     digits_q, digits_d;
  logic                  out_valid_q, out_valid_d;

  logic        [W:0]     bx;
  logic        [2:0]     win;
  logic        [PW-1:0]  pp;
  logic        [PW-1:0]  maj;
  logic                  last;
  logic                  accept;
`ifdef MULT_CSA_SEQ_EARLY_TERM_EN
  logic signed [W-1:0]   rest;
`endif

  assign accept = bus.in_valid & bus.in_ready;

  // Booth window for the current digit; bit -1 of the multiplier is zero
  always_comb begin
    bx  = {b_q, 1'b0};
    win = 3'(bx >> {i_q, 1'b0});
  end

  booth4_pp_sel u_pp_sel (
    .win    (win),
    .a_ext  (a_q),
    .na_ext (na_q),
    .idx    (i_q),
    .pp     (pp)
  );

  // Decide whether the digit being retired this cycle is the final one
  always_comb begin
`ifdef MULT_CSA_SEQ_EARLY_TERM_EN
    // Remaining digits are all zero once b[31:2i+1] is a pure sign run
    rest = b_q >>> {i_q, 1'b1};
    last = (rest == '0) || (rest == '1);
`else
    last = (i_q == 5'd15);
`endif
  end

  // Next-state logic: accept, per-digit 3:2 compression, result handshake
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    na_d        = na_q;
    b_d         = b_q;
    s_d         = s_q;
    c_d         = c_q;
    i_d         = i_q;
    digits_d    = digits_q;
    out_valid_d = out_valid_q;
    maj         = (s_q & c_q) | (s_q & pp) | (c_q & pp);
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = {{(PW-W){bus.a[W-1]}}, bus.a};
          na_d     = -a_d;
          b_d      = bus.b;
          s_d      = '0;
          c_d      = '0;
          i_d      = '0;
          digits_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        s_d      = s_q ^ c_q ^ pp;
        c_d      = {maj[PW-2:0], 1'b0};
        i_d      = i_q + 5'd1;
        digits_d = i_q + 5'd1;
        if (last) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result-row registers; reset discards any in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      i_q         <= '0;
      digits_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      i_q         <= i_d;
      digits_q    <= digits_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand registers: only meaningful after an accept, so no reset
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    na_q <= na_d;
    b_q  <= b_d;
  end

  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.row_s     = s_q;
  assign bus.row_c     = c_q;
  assign bus.digits    = digits_q;

endmodule
